// File: rtl/pkt_hdr_loader.sv
// pkt_hdr_loader: fetches per-packet headers from SRAM and hands them to proc.
// Ports: clk/rst; en_i, base_addr_i, pkt_cnt_i start a batch; sram_* is the
// clocked read port (data one cycle after address); pkt_hdr_o/start_o/ready_i
// form the proc handoff; busy_o, done_o, pkt_idx_o report batch progress.
// Optional: define PKT_HDR_LOADER_STAT_EN to add lat_o / lat_max_o.
module pkt_hdr_loader #(
  parameter int unsigned HDR_MAX_LEN = 64,
  parameter int unsigned PKT_STRIDE  = 256,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en_i,
  input  logic [31:0]                  base_addr_i,
  input  logic [CNT_W-1:0]             pkt_cnt_i,
  output logic                         sram_ce_o,
  output logic                         sram_we_o,
  output logic [31:0]                  sram_addr_o,
  output logic [3:0]                   sram_sel_o,
  input  logic [31:0]                  sram_data_i,
  output logic [HDR_MAX_LEN-1:0][7:0]  pkt_hdr_o,
  output logic                         start_o,
  input  logic                         ready_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [CNT_W-1:0]             pkt_idx_o
`ifdef PKT_HDR_LOADER_STAT_EN
  ,
  output logic [31:0]                  lat_o,
  output logic [31:0]                  lat_max_o
`endif
);

  localparam int unsigned NW = HDR_MAX_LEN / 4;
  localparam int unsigned WW = $clog2(NW + 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    PRESENT,
    ADVANCE,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [31:0]      cur_addr_q, cur_addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] idx_inc;
  logic [WW-1:0]    wcnt_q, wcnt_d;
  logic             rd_vld_q;
  logic [WW-1:0]    rd_w_q;
  logic             rdy_prev_q;
  logic             rdy_rise;
  logic             issue;
  logic [HDR_MAX_LEN-1:0][7:0] hdr_q;

  assign idx_inc  = idx_q + 1'b1;
  assign rdy_rise = ready_i & ~rdy_prev_q;

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    wcnt_d     = wcnt_q;
    issue      = 1'b0;
    start_o    = 1'b0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en_i) begin
          cur_addr_d = base_addr_i;
          cnt_d      = pkt_cnt_i;
          idx_d      = '0;
          wcnt_d     = '0;
          state_d    = (pkt_cnt_i == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        busy_o = 1'b1;
        issue  = (wcnt_q < WW'(NW));
        // One extra cycle after the last issue lets its data land.
        if (wcnt_q == WW'(NW)) begin
          wcnt_d  = '0;
          state_d = PRESENT;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      PRESENT: begin
        busy_o  = 1'b1;
        start_o = 1'b1;
        if (rdy_rise) state_d = ADVANCE;
      end
      ADVANCE: begin
        busy_o     = 1'b1;
        idx_d      = idx_inc;
        cur_addr_d = cur_addr_q + PKT_STRIDE;
        wcnt_d     = '0;
        state_d    = (idx_inc == cnt_q) ? DONE : FETCH;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign sram_ce_o   = issue;
  assign sram_we_o   = 1'b0;
  assign sram_sel_o  = issue ? 4'hF : 4'h0;
  assign sram_addr_o = issue ? (cur_addr_q + (32'(wcnt_q) << 2)) : 32'h0;
  assign pkt_hdr_o   = hdr_q;
  assign pkt_idx_o   = idx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cur_addr_q <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      wcnt_q     <= '0;
      rd_vld_q   <= 1'b0;
      rd_w_q     <= '0;
      rdy_prev_q <= 1'b0;
      hdr_q      <= '0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      wcnt_q     <= wcnt_d;
      rd_vld_q   <= issue;
      rd_w_q     <= wcnt_q;
      rdy_prev_q <= ready_i;
      // Big-endian word split: MSB byte is the earliest wire byte.
      for (int w = 0; w < int'(NW); w++) begin
        if (rd_vld_q && rd_w_q == WW'(w)) begin
          hdr_q[4*w]   <= sram_data_i[31:24];
          hdr_q[4*w+1] <= sram_data_i[23:16];
          hdr_q[4*w+2] <= sram_data_i[15:8];
          hdr_q[4*w+3] <= sram_data_i[7:0];
        end
      end
    end
  end

`ifdef PKT_HDR_LOADER_STAT_EN
  logic [31:0] lat_q;
  logic [31:0] lat_max_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_q     <= '0;
      lat_max_q <= '0;
    end else begin
      // The edge cycle itself is not counted, so lat_o equals the
      // number of cycles proc took to answer.
      if (state_q != PRESENT && state_d == PRESENT) begin
        lat_q <= '0;
      end else if (state_q == PRESENT && !rdy_rise &&
                   lat_q != 32'hFFFF_FFFF) begin
        lat_q <= lat_q + 32'd1;
      end
      if (state_q == IDLE && en_i) begin
        lat_max_q <= '0;
      end else if (state_q == PRESENT && lat_q > lat_max_q) begin
        lat_max_q <= lat_q;
      end
    end
  end

  assign lat_o     = lat_q;
  assign lat_max_o = lat_max_q;
`endif

endmodule
